// File: rtl/bist_scan_register_bank.sv
// State-register bank with capture, scan shift and MISR update modes plus a
// self-timed BIST session that compacts NPAT cycles and compares to GOLDEN.
module bist_scan_register_bank #(
  parameter int              WIDTH  = 19,
  parameter logic [WIDTH-1:0] POLY   = 19'h40023,
  parameter logic [WIDTH-1:0] SEED   = 19'h00001,
  parameter int              NPAT   = 256,
  parameter logic [WIDTH-1:0] GOLDEN = 19'h00000,
  localparam int             CW     = $clog2(NPAT + 1)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [1:0]       MODE,
  input  logic             START,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CW-1:0]    CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NPAT - 1);

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] q_r, q_nxt_s, misr_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             busy_r, done_r, pass_r;
  logic             done_nxt_s, pass_nxt_s, busy_nxt_s;

  function automatic logic misr_fb(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] poly);
    return ^(q & poly);
  endfunction

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] d);
    return {q[WIDTH-2:0], misr_fb(q, POLY)} ^ d;
  endfunction

  function automatic logic [WIDTH-1:0] mode_update(input logic [1:0] mode, input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] d, input logic si);
    logic [WIDTH-1:0] r;
    case (mode)
      2'b00:   r = d;
      2'b01:   r = {q[WIDTH-2:0], si};
      2'b10:   r = misr_step(q, d);
      2'b11:   r = q;
      default: r = q;
    endcase
    return r;
  endfunction

  assign misr_s = misr_step(q_r, D);

  // FSM state register
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decode; the final pattern edge leaves RUN
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath/flag next values; START in IDLE/DONE overrides MODE
  always_comb begin
    q_nxt_s    = q_r;
    cnt_nxt_s  = cnt_r;
    done_nxt_s = done_r;
    pass_nxt_s = pass_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          q_nxt_s    = SEED;
          cnt_nxt_s  = CNT_ZERO;
          done_nxt_s = 1'b0;
          pass_nxt_s = 1'b0;
        end else begin
          q_nxt_s    = mode_update(MODE, q_r, D, SI);
        end
      end
      ST_RUN: begin
        q_nxt_s   = misr_s;
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          done_nxt_s = 1'b1;
          pass_nxt_s = (misr_s == GOLDEN);
        end else begin
          done_nxt_s = 1'b0;
          pass_nxt_s = 1'b0;
        end
      end
      default: begin
        q_nxt_s    = '0;
        cnt_nxt_s  = CNT_ZERO;
        done_nxt_s = 1'b0;
        pass_nxt_s = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_RUN);
  end

  // Registered datapath and status outputs
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      q_r    <= '0;
      cnt_r  <= CNT_ZERO;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      cnt_r  <= cnt_nxt_s;
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      pass_r <= pass_nxt_s;
    end
  end

  assign Q    = q_r;
  assign SO   = q_r[WIDTH-1];
  assign BUSY = busy_r;
  assign DONE = done_r;
  assign PASS = pass_r;
  assign CNT  = cnt_r;

endmodule

// File: tb/tb_bist_scan_register_bank.sv
// Randomized and directed bench for bist_scan_register_bank against a
// session-level reference model; two instances differ only in GOLDEN.
module tb_bist_scan_register_bank;

  localparam int         WIDTH  = 4;
  localparam logic [3:0] POLY   = 4'b1001;
  localparam logic [3:0] SEED   = 4'b0001;
  localparam int         NPAT   = 3;
  localparam logic [3:0] GOLD_A = 4'hF;
  localparam logic [3:0] GOLD_B = 4'hE;
  localparam int         CW     = $clog2(NPAT + 1);

  logic          CK = 1'b0;
  logic          RST;
  logic [1:0]    MODE;
  logic          START;
  logic [3:0]    D;
  logic          SI;
  logic [3:0]    q_a, q_b;
  logic          so_a, so_b, busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_q;
  bit         m_run, m_done, m_pass_a, m_pass_b;
  int         m_cnt;

  bist_scan_register_bank #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED), .NPAT(NPAT), .GOLDEN(GOLD_A)) u_dut_a (
    .CK(CK), .RST(RST), .MODE(MODE), .START(START), .D(D), .SI(SI),
    .Q(q_a), .SO(so_a), .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .CNT(cnt_a));

  bist_scan_register_bank #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED), .NPAT(NPAT), .GOLDEN(GOLD_B)) u_dut_b (
    .CK(CK), .RST(RST), .MODE(MODE), .START(START), .D(D), .SI(SI),
    .Q(q_b), .SO(so_b), .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .CNT(cnt_b));

  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_misr(input logic [3:0] q, input logic [3:0] d);
    logic fb = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (POLY[i]) fb = fb ^ q[i];
    end
    return ((q << 1) | {3'b000, fb}) ^ d;
  endfunction

  task automatic model_reset();
    m_q = 4'h0; m_run = 0; m_done = 0; m_pass_a = 0; m_pass_b = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (m_run) begin
      m_q = ref_misr(m_q, D);
      m_cnt++;
      if (m_cnt == NPAT) begin
        m_run = 0; m_done = 1;
        m_pass_a = (m_q == GOLD_A);
        m_pass_b = (m_q == GOLD_B);
      end
    end else if (START) begin
      m_q = SEED; m_cnt = 0; m_run = 1; m_done = 0; m_pass_a = 0; m_pass_b = 0;
    end else begin
      case (MODE)
        2'b00:   m_q = D;
        2'b01:   m_q = {m_q[2:0], SI};
        2'b10:   m_q = ref_misr(m_q, D);
        default: m_q = m_q;
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".q"},     32'(q_a),    32'(m_q));
    check({tag, ".qb"},    32'(q_b),    32'(m_q));
    check({tag, ".so"},    32'(so_a),   32'(m_q[3]));
    check({tag, ".busy"},  32'(busy_a), 32'(m_run));
    check({tag, ".done"},  32'(done_a), 32'(m_done));
    check({tag, ".pass"},  32'(pass_a), 32'(m_pass_a));
    check({tag, ".passb"}, 32'(pass_b), 32'(m_pass_b));
    check({tag, ".cnt"},   32'(cnt_a),  32'(m_cnt));
  endtask

  task automatic cycle(input string tag);
    @(posedge CK);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    RST = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    RST = 1'b0;
  endtask

  initial begin
    logic [3:0] so_seq;
    logic [3:0] si_seq;
    RST = 1'b1; MODE = 2'b00; START = 1'b0; D = 4'h0; SI = 1'b0;
    model_reset();
    #12;
    compare_all("reset");
    RST = 1'b0;

    // capture
    D = 4'hA; cycle("cap1"); check("cap_a", 32'(q_a), 32'h0A);
    D = 4'h5; cycle("cap2"); check("cap_5", 32'(q_a), 32'h05);

    // scan shift from zero
    D = 4'h0; cycle("clr");
    MODE = 2'b01;
    si_seq = 4'b1011;
    for (int i = 3; i >= 0; i--) begin
      SI = si_seq[i];
      cycle("scan");
      so_seq[i] = so_a;
    end
    check("scan_q", 32'(q_a), 32'hB);
    check("scan_so", 32'(so_seq), 32'h1);

    // BIST pass / fail
    MODE = 2'b00; D = 4'h0; START = 1'b1;
    cycle("bist0"); check("bist_seed", 32'(q_a), 32'h1);
    START = 1'b0;
    cycle("bist1"); check("bist_q1", 32'(q_a), 32'h3);
    cycle("bist2"); check("bist_q2", 32'(q_a), 32'h7);
    cycle("bist3");
    check("bist_qf",   32'(q_a),    32'hF);
    check("bist_done", 32'(done_a), 32'h1);
    check("bist_pass", 32'(pass_a), 32'h1);
    check("bist_busy", 32'(busy_a), 32'h0);
    check("bist_cnt",  32'(cnt_a),  32'h3);
    check("fail_done", 32'(done_b), 32'h1);
    check("fail_pass", 32'(pass_b), 32'h0);
    cycle("done_hold");
    check("cnt_sat", 32'(cnt_a), 32'h3);

    // restart then reset mid-RUN
    START = 1'b1; cycle("restart"); check("restart_done", 32'(done_b), 32'h0);
    START = 1'b0;
    cycle("run_a"); cycle("run_b");
    async_reset("midrun");
    check("rst_q", 32'(q_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    MODE = 2'b00; D = 4'h6; cycle("post_rst"); check("post_rst_q", 32'(q_a), 32'h6);

    // RUN isolation
    START = 1'b1; D = 4'h0; cycle("iso0");
    for (int i = 0; i < 3; i++) begin
      MODE = 2'b01; START = 1'($urandom_range(0, 1)); SI = 1'($urandom_range(0, 1));
      cycle("iso");
    end
    START = 1'b0;
    check("iso_q", 32'(q_a), 32'hF);
    check("iso_pass", 32'(pass_a), 32'h1);
    MODE = 2'b11; cycle("hold1"); cycle("hold2");
    check("hold_q", 32'(q_a), 32'hF);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      MODE  = 2'($urandom_range(0, 3));
      D     = 4'($urandom_range(0, 15));
      SI    = 1'($urandom_range(0, 1));
      START = ($urandom_range(0, 7) == 0);
      cycle("rand");
      if ($urandom_range(0, 63) == 0) async_reset("rand_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
